mac_operand_sequencer: RTL and testbench

//  Initiator/feeder for the free-running 4-bit array-multiplier + Kogge-Stone accumulator MAC.

---
 rtl/mac_operand_sequencer_if.sv | 36 +++
 rtl/mac_operand_sequencer.sv | 117 +++++++++++
 tb/tb_mac_operand_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_sequencer_if.sv
// rtl/mac_operand_sequencer_if.sv - operand, MAC-side and result signals of the MAC operand sequencer
interface mac_operand_sequencer_if #(
    parameter int W         = 4,
    parameter int MAX_TERMS = 16
);
    localparam int CW = $clog2(MAX_TERMS + 1);

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_last;

    logic [W-1:0]   mac_a;
    logic [W-1:0]   mac_b;
    logic           mac_cin;
    logic           mac_clr;
    logic [2*W-1:0] mac_result;
    logic           mac_cout;

    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_data;
    logic           res_ovf;
    logic [CW-1:0]  res_terms;

    modport master (
        output in_valid, in_a, in_b, in_last, res_ready, mac_result, mac_cout,
        input  in_ready, mac_a, mac_b, mac_cin, mac_clr, res_valid, res_data, res_ovf, res_terms
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, res_ready, mac_result, mac_cout,
        output in_ready, mac_a, mac_b, mac_cin, mac_clr, res_valid, res_data, res_ovf, res_terms
    );
endinterface

// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - operand FIFO and sequencer that feeds a free-running MAC and returns dot products
module mac_operand_sequencer #(
    parameter int W         = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_TERMS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mac_operand_sequencer_if.slave bus
);
    localparam int CW = $clog2(MAX_TERMS + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, CAPTURE, HOLD} state_t;

    state_t         state;
    state_t         state_nx;

    // FIFO entry layout: {last, a, b}
    logic [2*W:0]   mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [2*W:0]   head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    logic           act;
    logic           ovf;
    logic           drain_done;
    logic [CW-1:0]  count;
    logic           count_sat;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign push      = bus.in_valid && !full;
    assign pop       = (state == ISSUE) && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign count_sat = (count == CW'(MAX_TERMS));

    assign bus.in_ready = !full;
    assign bus.mac_cin  = 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.in_last, bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DRAIN spans two cycles so the last product and its carry are settled before capture
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = CLEAR;
            CLEAR:   state_nx = ISSUE;
            ISSUE:   if (pop && head[2*W]) state_nx = DRAIN;
            DRAIN:   if (drain_done) state_nx = CAPTURE;
            CAPTURE: state_nx = HOLD;
            HOLD:    if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.mac_a     <= '0;
            bus.mac_b     <= '0;
            bus.mac_clr   <= 1'b1;
            act           <= 1'b0;
            ovf           <= 1'b0;
            count         <= '0;
            drain_done    <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_ovf   <= 1'b0;
            bus.res_terms <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            // zero operands whenever nothing is popped so the accumulator holds
            bus.mac_clr <= (state_nx == CLEAR);
            bus.mac_a   <= pop ? head[2*W-1:W] : '0;
            bus.mac_b   <= pop ? head[W-1:0]   : '0;
            act         <= pop;
            drain_done  <= (state == DRAIN) && !drain_done;

            if (state == CLEAR) begin
                ovf   <= 1'b0;
                count <= '0;
            end else begin
                ovf <= ovf | (act & bus.mac_cout) | (pop & count_sat);
                if (pop && !count_sat) count <= count + 1'b1;
            end

            if (state == CAPTURE) begin
                bus.res_data  <= bus.mac_result;
                bus.res_ovf   <= ovf;
                bus.res_terms <= count;
                bus.res_valid <= 1'b1;
            end else if (state == HOLD && bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb/tb_mac_operand_sequencer.sv - scoreboard bench for the MAC operand sequencer with a behavioural MAC
module tb_mac_operand_sequencer;
    localparam int W    = 4;
    localparam int MAXT = 16;

    typedef struct {
        int data;
        int ovf;
        int terms;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   ready_mode = 0;
    exp_t exp_q[$];
    int   grp_sum = 0;
    int   grp_n = 0;
    int   last_data = -1;
    int   last_ovf = -1;
    int   last_terms = -1;

    mac_operand_sequencer_if #(.W(W), .MAX_TERMS(MAXT)) bus ();

    mac_operand_sequencer #(.W(W), .DEPTH(4), .MAX_TERMS(MAXT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running MAC: accumulator register cleared asynchronously by mac_clr
    logic [7:0] acc = '0;
    logic [8:0] sum_ext;
    assign sum_ext        = {1'b0, acc} + (9'(bus.mac_a) * 9'(bus.mac_b));
    assign bus.mac_result = acc;
    assign bus.mac_cout   = sum_ext[8];

    always @(posedge clk or posedge bus.mac_clr) begin
        if (bus.mac_clr) acc <= '0;
        else             acc <= sum_ext[7:0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model and result monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                grp_sum = 0;
                grp_n   = 0;
            end else begin
                if (bus.res_valid && bus.res_ready) begin
                    check("sb_has_expect", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("res_data", int'(bus.res_data), e.data);
                        check("res_ovf", int'(bus.res_ovf), e.ovf);
                        check("res_terms", int'(bus.res_terms), e.terms);
                    end
                    last_data  = int'(bus.res_data);
                    last_ovf   = int'(bus.res_ovf);
                    last_terms = int'(bus.res_terms);
                end
                if (bus.in_valid && bus.in_ready) begin
                    grp_sum += int'(bus.in_a) * int'(bus.in_b);
                    grp_n++;
                    if (bus.in_last) begin
                        e.data  = grp_sum % 256;
                        e.ovf   = ((grp_sum >= 256) || (grp_n > MAXT)) ? 1 : 0;
                        e.terms = (grp_n > MAXT) ? MAXT : grp_n;
                        exp_q.push_back(e);
                        grp_sum = 0;
                        grp_n   = 0;
                    end
                end
            end
        end
    end

    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.res_ready = 1'b1;
                1:       bus.res_ready = 1'($urandom_range(0, 1));
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic l);
        int  t = 0;
        logic ok = 1'b0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 200);
        if (!ok) check("send_timeout", int'(ok), 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_mac_a(input int val, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(bus.mac_a) != val && n < 100);
        check(name, int'(bus.mac_a), val);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.res_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int n;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mac_clr", int'(bus.mac_clr), 1);
        check("rst_mac_a", int'(bus.mac_a), 0);
        check("rst_mac_b", int'(bus.mac_b), 0);
        check("rst_mac_cin", int'(bus.mac_cin), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_res_data", int'(bus.res_data), 0);
        check("rst_res_terms", int'(bus.res_terms), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1;
        check("rel_mac_clr_held", int'(bus.mac_clr), 1);
        idle(1);
        check("rel_mac_clr_drop", int'(bus.mac_clr), 0);

        // single term and its latency from the pop
        send(4'd3, 4'd5, 1'b1);
        wait_mac_a(3, "t1_issue_a");
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.res_valid && lat < 20);
        check("t1_latency", lat, 3);
        idle(1);
        wait_drain("t1_drain");
        check("t1_data", last_data, 15);
        check("t1_terms", last_terms, 1);
        check("t1_ovf", last_ovf, 0);

        send(4'd2, 4'd3, 1'b0);
        send(4'd4, 4'd5, 1'b0);
        send(4'd1, 4'd1, 1'b1);
        wait_drain("t2_drain");
        check("t2_data", last_data, 27);
        check("t2_terms", last_terms, 3);

        send(4'd15, 4'd15, 1'b0);
        send(4'd15, 4'd15, 1'b1);
        wait_drain("t3_drain");
        check("t3_data", last_data, 194);
        check("t3_ovf", last_ovf, 1);

        // operand gap while the FIFO runs dry
        send(4'd2, 4'd2, 1'b0);
        wait_mac_a(2, "t4_issue_a");
        @(negedge clk);
        check("t4_gap_a", int'(bus.mac_a), 0);
        check("t4_gap_b", int'(bus.mac_b), 0);
        idle(1);
        send(4'd3, 4'd3, 1'b1);
        wait_drain("t4_drain");
        check("t4_data", last_data, 13);

        // result held while the FIFO fills behind it
        ready_mode = 2;
        send(4'd2, 4'd3, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 50);
        check("t5_valid", int'(bus.res_valid), 1);
        idle(1);
        send(4'd1, 4'd1, 1'b0);
        send(4'd1, 4'd1, 1'b0);
        send(4'd1, 4'd1, 1'b0);
        send(4'd1, 4'd1, 1'b1);
        check("t5_in_ready_full", int'(bus.in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_data", int'(bus.res_data), 6);
            check("t5_hold_valid", int'(bus.res_valid), 1);
        end
        idle(1);
        ready_mode = 0;
        wait_drain("t5_drain");
        check("t5_next_data", last_data, 4);
        check("t5_next_terms", last_terms, 4);

        // reset in the middle of issuing
        send(4'd7, 4'd7, 1'b0);
        send(4'd7, 4'd7, 1'b0);
        wait_mac_a(7, "t6_issue_a");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_res_valid", int'(bus.res_valid), 0);
        check("t6_mac_clr", int'(bus.mac_clr), 1);
        check("t6_mac_a", int'(bus.mac_a), 0);
        check("t6_in_ready", int'(bus.in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4'd1, 4'd1, 1'b1);
        wait_drain("t6_drain");
        check("t6_data", last_data, 1);
        check("t6_terms", last_terms, 1);

        // randomized dot products with random backpressure
        ready_mode = 1;
        for (int g = 0; g < 40; g++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 19)) : int'($urandom_range(1, 5));
            for (int t = 0; t < len; t++) begin
                send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), (t == len - 1));
                idle(int'($urandom_range(0, 2)));
            end
        end
        ready_mode = 0;
        wait_drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
